ram_1p_arb_ctrl: RTL and testbench

Controller that sequences and shares one single-port RAM macro (generic 1p RAM or its bad-bit test wrapper) between two requesters, port A and port B. After reset it zero-fills every RAM word. It then arbitrates A/B requests round-robin onto the RAM port and returns read data and response valids to the winning requester. It sits between the core-side memory interfaces and the RAM instance.

---
 rtl/ram_1p_arb_ctrl.sv | 103 ++++++++++
 tb/tb_ram_1p_arb_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_1p_arb_ctrl.sv
// ram_1p_arb_ctrl: zero-fills a single-port RAM after reset, then shares it round-robin between ports A and B
module ram_1p_arb_ctrl #(
    parameter int Width = 32,
    parameter int Depth = 128,
    parameter bit InitZero = 1'b1,
    localparam int Aw = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             a_req_i,
    output logic             a_gnt_o,
    input  logic             a_we_i,
    input  logic [Aw-1:0]    a_addr_i,
    input  logic [Width-1:0] a_wdata_i,
    input  logic [Width-1:0] a_wmask_i,
    output logic             a_rvalid_o,
    output logic [Width-1:0] a_rdata_o,
    input  logic             b_req_i,
    output logic             b_gnt_o,
    input  logic             b_we_i,
    input  logic [Aw-1:0]    b_addr_i,
    input  logic [Width-1:0] b_wdata_i,
    input  logic [Width-1:0] b_wmask_i,
    output logic             b_rvalid_o,
    output logic [Width-1:0] b_rdata_o,
    output logic             ram_req_o,
    output logic             ram_write_o,
    output logic [Aw-1:0]    ram_addr_o,
    output logic [Width-1:0] ram_wdata_o,
    output logic [Width-1:0] ram_wmask_o,
    input  logic [Width-1:0] ram_rdata_i,
    output logic             init_done_o
);
    typedef enum logic [1:0] {RST, INIT, RUN} state_e;

    state_e          state_q, state_d;
    logic [Aw-1:0]   cnt_q, cnt_d;
    logic            last_q, last_d;
    logic            a_rv_q, a_rv_d;
    logic            b_rv_q, b_rv_d;
    logic            rd_q, rd_d;
    logic            run, init;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= RST;
        else       state_q <= state_d;
    end

    // Next state: one RST cycle, optional fill of Depth words, then RUN forever
    always_comb begin
        state_d = state_q;
        case (state_q)
            RST:     state_d = InitZero ? INIT : RUN;
            INIT:    state_d = (cnt_q == Aw'(Depth - 1)) ? RUN : INIT;
            default: state_d = RUN;
        endcase
    end

    // Outputs: grants (last_q = 1 means B was last served) and RAM port drive
    always_comb begin
        run         = state_q == RUN;
        init        = state_q == INIT;
        a_gnt_o     = run && a_req_i && (!b_req_i || last_q);
        b_gnt_o     = run && b_req_i && !a_gnt_o;
        ram_req_o   = init || a_gnt_o || b_gnt_o;
        ram_write_o = init || (a_gnt_o && a_we_i) || (b_gnt_o && b_we_i);
        ram_addr_o  = init ? cnt_q : a_gnt_o ? a_addr_i : b_gnt_o ? b_addr_i : '0;
        ram_wdata_o = a_gnt_o ? a_wdata_i : b_gnt_o ? b_wdata_i : '0;
        ram_wmask_o = init ? '1 : a_gnt_o ? a_wmask_i : b_gnt_o ? b_wmask_i : '0;
        init_done_o = run;
        a_rvalid_o  = a_rv_q;
        b_rvalid_o  = b_rv_q;
        a_rdata_o   = (a_rv_q && rd_q) ? ram_rdata_i : '0;
        b_rdata_o   = (b_rv_q && rd_q) ? ram_rdata_i : '0;
    end

    // Datapath next values: fill counter, arbitration history, response tags
    always_comb begin
        cnt_d  = init ? cnt_q + 1'b1 : '0;
        last_d = a_gnt_o ? 1'b0 : b_gnt_o ? 1'b1 : last_q;
        a_rv_d = a_gnt_o;
        b_rv_d = b_gnt_o;
        rd_d   = (a_gnt_o || b_gnt_o) && !ram_write_o;
    end

    // Datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            last_q <= 1'b1;
            a_rv_q <= 1'b0;
            b_rv_q <= 1'b0;
            rd_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
            a_rv_q <= a_rv_d;
            b_rv_q <= b_rv_d;
            rd_q   <= rd_d;
        end
    end
endmodule

// File: tb/tb_ram_1p_arb_ctrl.sv
// tb_ram_1p_arb_ctrl: directed checks of fill, arbitration and response path against a RAM model
module tb_ram_1p_arb_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_req = 1'b0, a_we = 1'b0, a_gnt, a_rvalid;
    logic [3:0]  a_addr = '0;
    logic [31:0] a_wdata = '0, a_wmask = '0, a_rdata;
    logic        b_req = 1'b0, b_we = 1'b0, b_gnt, b_rvalid;
    logic [3:0]  b_addr = '0;
    logic [31:0] b_wdata = '0, b_wmask = '0, b_rdata;
    logic        ram_req, ram_write, init_done;
    logic [3:0]  ram_addr;
    logic [31:0] ram_wdata, ram_wmask;
    logic [31:0] ram_rdata = '0;
    logic [31:0] mem [16];

    logic        rst2 = 1'b1;
    logic        c_a_gnt, c_a_rvalid, c_b_gnt, c_b_rvalid;
    logic [31:0] c_a_rdata, c_b_rdata, c_ram_wdata, c_ram_wmask;
    logic        c_ram_req, c_ram_write, c_init_done;
    logic [3:0]  c_ram_addr;
    logic [31:0] zero32 = '0;
    logic [3:0]  zero4 = '0;
    logic [3:0]  c_a_addr = 4'd3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_1p_arb_ctrl #(.Width(32), .Depth(16), .InitZero(1'b1)) dut (
        .clk_i(clk), .rst_i(rst),
        .a_req_i(a_req), .a_gnt_o(a_gnt), .a_we_i(a_we), .a_addr_i(a_addr),
        .a_wdata_i(a_wdata), .a_wmask_i(a_wmask), .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata),
        .b_req_i(b_req), .b_gnt_o(b_gnt), .b_we_i(b_we), .b_addr_i(b_addr),
        .b_wdata_i(b_wdata), .b_wmask_i(b_wmask), .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata),
        .ram_req_o(ram_req), .ram_write_o(ram_write), .ram_addr_o(ram_addr),
        .ram_wdata_o(ram_wdata), .ram_wmask_o(ram_wmask), .ram_rdata_i(ram_rdata),
        .init_done_o(init_done)
    );

    ram_1p_arb_ctrl #(.Width(32), .Depth(16), .InitZero(1'b0)) dut_nofill (
        .clk_i(clk), .rst_i(rst2),
        .a_req_i(1'b1), .a_gnt_o(c_a_gnt), .a_we_i(1'b0), .a_addr_i(c_a_addr),
        .a_wdata_i(zero32), .a_wmask_i(zero32), .a_rvalid_o(c_a_rvalid), .a_rdata_o(c_a_rdata),
        .b_req_i(1'b0), .b_gnt_o(c_b_gnt), .b_we_i(1'b0), .b_addr_i(zero4),
        .b_wdata_i(zero32), .b_wmask_i(zero32), .b_rvalid_o(c_b_rvalid), .b_rdata_o(c_b_rdata),
        .ram_req_o(c_ram_req), .ram_write_o(c_ram_write), .ram_addr_o(c_ram_addr),
        .ram_wdata_o(c_ram_wdata), .ram_wmask_o(c_ram_wmask), .ram_rdata_i(zero32),
        .init_done_o(c_init_done)
    );

    // RAM model: masked write, read data one cycle after the request, junk initial contents
    initial for (int i = 0; i < 16; i++) mem[i] = 32'hA5A5_0000 | i;
    always @(posedge clk) begin
        if (ram_req) begin
            if (ram_write) mem[ram_addr] <= (mem[ram_addr] & ~ram_wmask) | (ram_wdata & ram_wmask);
            else           ram_rdata <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_reset();
        chk("rst_a_gnt", {31'd0, a_gnt}, 0);
        chk("rst_b_gnt", {31'd0, b_gnt}, 0);
        chk("rst_a_rvalid", {31'd0, a_rvalid}, 0);
        chk("rst_b_rvalid", {31'd0, b_rvalid}, 0);
        chk("rst_a_rdata", a_rdata, 0);
        chk("rst_b_rdata", b_rdata, 0);
        chk("rst_ram_req", {31'd0, ram_req}, 0);
        chk("rst_ram_write", {31'd0, ram_write}, 0);
        chk("rst_ram_addr", {28'd0, ram_addr}, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_ram_wmask", ram_wmask, 0);
        chk("rst_init_done", {31'd0, init_done}, 0);
    endtask

    task automatic chk_rst_state();
        chk("rststate_ram_req", {31'd0, ram_req}, 0);
        chk("rststate_init_done", {31'd0, init_done}, 0);
        chk("rststate_a_gnt", {31'd0, a_gnt}, 0);
    endtask

    task automatic do_fill(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("fill_req", {31'd0, ram_req}, 1);
            chk("fill_write", {31'd0, ram_write}, 1);
            chk("fill_addr", {28'd0, ram_addr}, i);
            chk("fill_wdata", ram_wdata, 0);
            chk("fill_wmask", ram_wmask, 32'hFFFF_FFFF);
            chk("fill_a_gnt", {31'd0, a_gnt}, 0);
            chk("fill_init_done", {31'd0, init_done}, 0);
        end
    endtask

    initial begin
        a_req = 1'b1; a_we = 1'b1; a_addr = 4'd5; a_wdata = 32'hDEAD_BEEF; a_wmask = 32'hFFFF_FFFF;
        b_wmask = 32'hFFFF_FFFF;
        @(negedge clk);
        chk_reset();
        chk("nf_rst_ram_req", {31'd0, c_ram_req}, 0);
        chk("nf_rst_init_done", {31'd0, c_init_done}, 0);
        @(posedge clk); #1 rst2 = 1'b0;
        @(negedge clk);
        chk("nf_rststate_ram_req", {31'd0, c_ram_req}, 0);
        chk("nf_rststate_init_done", {31'd0, c_init_done}, 0);
        chk("nf_rststate_a_gnt", {31'd0, c_a_gnt}, 0);
        @(negedge clk);
        chk("nf_run_init_done", {31'd0, c_init_done}, 1);
        chk("nf_run_a_gnt", {31'd0, c_a_gnt}, 1);
        chk("nf_run_ram_req", {31'd0, c_ram_req}, 1);
        chk("nf_run_ram_write", {31'd0, c_ram_write}, 0);
        chk("nf_run_ram_addr", {28'd0, c_ram_addr}, 3);
        chk_reset();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk_rst_state();
        do_fill(16);
        @(negedge clk);
        chk("run_init_done", {31'd0, init_done}, 1);
        chk("wr5_a_gnt", {31'd0, a_gnt}, 1);
        chk("wr5_ram_write", {31'd0, ram_write}, 1);
        chk("wr5_ram_addr", {28'd0, ram_addr}, 5);
        chk("wr5_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
        @(posedge clk); #1 a_we = 1'b0;
        @(negedge clk);
        chk("rd5_a_gnt", {31'd0, a_gnt}, 1);
        chk("rd5_ram_write", {31'd0, ram_write}, 0);
        chk("wr5_a_rvalid", {31'd0, a_rvalid}, 1);
        chk("wr5_a_rdata", a_rdata, 0);
        chk("wr5_b_rvalid", {31'd0, b_rvalid}, 0);
        @(posedge clk); #1 a_req = 1'b0;
        @(negedge clk);
        chk("rd5_a_rvalid", {31'd0, a_rvalid}, 1);
        chk("rd5_a_rdata", a_rdata, 32'hDEAD_BEEF);
        chk("rd5_b_rvalid", {31'd0, b_rvalid}, 0);
        chk("idle_ram_req", {31'd0, ram_req}, 0);
        chk("idle_ram_addr", {28'd0, ram_addr}, 0);
        @(posedge clk); #1 a_req = 1'b1; a_we = 1'b1; a_addr = 4'd1; a_wdata = 32'h1111_1111;
        @(negedge clk);
        chk("wr1_a_gnt", {31'd0, a_gnt}, 1);
        @(posedge clk); #1 a_req = 1'b0; b_req = 1'b1; b_we = 1'b1; b_addr = 4'd2; b_wdata = 32'h2222_2222;
        @(negedge clk);
        chk("wr2_b_gnt", {31'd0, b_gnt}, 1);
        chk("wr2_a_gnt", {31'd0, a_gnt}, 0);
        chk("wr1_a_rvalid", {31'd0, a_rvalid}, 1);
        @(posedge clk); #1 b_we = 1'b0; a_req = 1'b1; a_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rr_a_gnt", {31'd0, a_gnt}, (k % 2 == 0) ? 1 : 0);
            chk("rr_b_gnt", {31'd0, b_gnt}, (k % 2 == 0) ? 0 : 1);
            chk("rr_ram_addr", {28'd0, ram_addr}, (k % 2 == 0) ? 1 : 2);
            if (k == 0) begin
                chk("rr0_b_rvalid", {31'd0, b_rvalid}, 1);
                chk("rr0_b_rdata", b_rdata, 0);
            end else if (k % 2 == 1) begin
                chk("rr_a_rvalid", {31'd0, a_rvalid}, 1);
                chk("rr_a_rdata", a_rdata, 32'h1111_1111);
                chk("rr_b_rvalid_lo", {31'd0, b_rvalid}, 0);
            end else begin
                chk("rr_b_rvalid", {31'd0, b_rvalid}, 1);
                chk("rr_b_rdata", b_rdata, 32'h2222_2222);
                chk("rr_a_rvalid_lo", {31'd0, a_rvalid}, 0);
            end
        end
        @(posedge clk); #1 a_req = 1'b0; b_req = 1'b0;
        @(negedge clk);
        chk("rr_last_b_rvalid", {31'd0, b_rvalid}, 1);
        chk("rr_last_b_rdata", b_rdata, 32'h2222_2222);
        chk("rr_last_a_rvalid", {31'd0, a_rvalid}, 0);
        @(posedge clk); #1 b_req = 1'b1; b_addr = 4'd9;
        @(negedge clk);
        chk("rd9_b_gnt", {31'd0, b_gnt}, 1);
        @(posedge clk); #1 b_req = 1'b0;
        @(negedge clk);
        chk("rd9_b_rvalid", {31'd0, b_rvalid}, 1);
        chk("rd9_b_rdata", b_rdata, 0);
        chk("rd9_a_rvalid", {31'd0, a_rvalid}, 0);
        @(posedge clk); #1 rst = 1'b1; a_req = 1'b1; a_we = 1'b0; a_addr = 4'd5;
        @(negedge clk);
        chk_reset();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk_rst_state();
        do_fill(7);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk_reset();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk_rst_state();
        do_fill(16);
        @(negedge clk);
        chk("refill_init_done", {31'd0, init_done}, 1);
        chk("refill_a_gnt", {31'd0, a_gnt}, 1);
        chk("refill_ram_write", {31'd0, ram_write}, 0);
        chk("refill_ram_addr", {28'd0, ram_addr}, 5);
        @(posedge clk); #1 a_req = 1'b0;
        @(negedge clk);
        chk("refill_a_rvalid", {31'd0, a_rvalid}, 1);
        chk("refill_a_rdata", a_rdata, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
